mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//  MEM stage plus MEM/WB pipeline register, directly downstream of EX.
//  - Consumes the EX/MEM register: ALU result/address, store data, rd, control bits.
//  - Runs the D-cache request/stall handshake and raises the memory stall to the pipeline.
//  - Drives RegWrite_mem, rd_mem and wdata_wb back to EX forwarding and to the register file.
// PARAMETERS
//  DATA_W  32  data width of the ALU result, store data and cache data
//  ADDR_W  30  word-address width to the D-cache (byte address [31:2])
// PORTS
//  clk            in   1       clock, all state updates on posedge
//  rst_n          in   1       synchronous active-low reset
//  mem_addr_D     in   DATA_W  ALU result / byte address from EX
//  mem_wdata_D    in   DATA_W  store data from EX
//  rd_ex          in   5       destination register from EX
//  memread_ex     in   1       load in MEM
//  memwrite_ex    in   1       store in MEM
//  RegWrite_ex    in   1       writeback enable from EX
//  MemToReg_ex    in   1       writeback source select (1 = load data)
//  stall_ext      in   1       stall from other sources (I-cache, hazard unit)
//  DCACHE_stall   in   1       cache busy; combinational response to the request
//  DCACHE_rdata   in   DATA_W  read data, valid in the cycle DCACHE_stall=0 with ren=1
//  DCACHE_ren     out  1       read request
//  DCACHE_wen     out  1       write request
//  DCACHE_addr    out  ADDR_W  word address, = mem_addr_D[31:2]
//  DCACHE_wdata   out  DATA_W  write data
//  stall_mem      out  1       D-cache stall to the pipeline
//  RegWrite_mem   out  1       MEM/WB writeback enable
//  rd_mem         out  5       MEM/WB destination register
//  wdata_wb       out  DATA_W  writeback data, combinational from MEM/WB regs
// BEHAVIOUR
//  - Reset values: state=IDLE; RegWrite_mem=0, rd_mem=0; MEM/WB data regs=0.
//  - Reset is applied in the same cycle rst_n is sampled low, including mid-transaction.
//  - mem_op = memread_ex|memwrite_ex. req = mem_op & (state!=HELD).
//  - ren = req&memread_ex; wen = req&memwrite_ex; both are never 1 together.
//  - addr/wdata are driven combinationally from the EX regs; EX holds them during any stall.
//  - stall_mem = req & DCACHE_stall.
//  - adv = ~stall_mem & ~stall_ext.
//  - FSM:
//    - IDLE: if req & DCACHE_stall -> BUSY.
//      If req & ~DCACHE_stall & stall_ext -> HELD and capture rdata into hold_q.
//      Otherwise stay in IDLE.
//    - BUSY: req stays asserted. When DCACHE_stall=0: go to HELD (capture rdata) if stall_ext,
//      else go to IDLE. An in-flight request is never re-issued.
//    - HELD: request is deasserted so the access is not repeated. The load data comes from hold_q.
//      When stall_ext=0, the MEM/WB regs update and the FSM returns to IDLE.
//  - Load data to MEM/WB = (state==HELD) ? hold_q : DCACHE_rdata.
//  - MEM/WB regs load on adv: RegWrite, rd, MemToReg, alu (=mem_addr_D), rdata.
//    With adv=0 they hold.
//  - A cache hit with stall_ext=0 completes in 1 cycle: EX reg -> MEM/WB reg.
//  - A miss adds one cycle per DCACHE_stall=1 cycle.
//  - wdata_wb = MemToReg_wb ? rdata_wb : alu_wb.
//  - Non-memory instructions never assert req; only stall_ext can hold them.
//  - Back-to-back memory ops: the next op issues its request in the cycle after adv.
//  - Stores load RegWrite=0 and ignore rdata.
//  - Misaligned addresses: bits [1:0] are dropped, and no exception is raised.
// CONFIGURATION
//  - ENDIAN_SWAP_EN defined: byte-reverse {b0,b1,b2,b3} in two places.
//    - On DCACHE_wdata (from mem_wdata_D).
//    - On DCACHE_rdata, before hold_q / MEM/WB capture.
//  - ENDIAN_SWAP_EN undefined: data passes through unchanged. Timing is identical either way.
// TESTING
//  - Reset: hold rst_n=0 with memread_ex=1 -> ren=0 and stall_mem=0.
//    RegWrite_mem=0, rd_mem=0 and wdata_wb=0 after the first edge.
//  - ALU op: RegWrite_ex=1, rd_ex=5, mem_addr_D=0x1234 -> next cycle rd_mem=5, wdata_wb=0x1234.
//    ren=wen=0 throughout.
//  - Load hit: memread_ex=1, MemToReg_ex=1, addr=0x100, DCACHE_stall=0, rdata=0xCAFEBABE.
//    Expect DCACHE_addr=0x40 and stall_mem=0. Next cycle wdata_wb=0xCAFEBABE.
//    With ENDIAN_SWAP_EN, next cycle wdata_wb=0xBEBAFECA.
//  - Store miss: memwrite_ex=1, wdata=0x11223344, DCACHE_stall=1 for 3 cycles.
//    Expect stall_mem=1 for 3 cycles, wen held with constant addr/data.
//    Expect RegWrite_mem unchanged until the completion edge.
//  - Hit under stall_ext=1 for 2 cycles, load rdata=0xA5 -> state HELD.
//    ren drops after the hit cycle and the request is not re-issued.
//    wdata_wb=0xA5 in the cycle after stall_ext falls.
//  - Reset mid-miss (BUSY) -> state IDLE, ren=0 and stall_mem=0 in the next cycle.

Source files
------------

// File: rtl/mem_wb_stage.sv
// ============================================================================
//  Module   : mem_wb_stage
//  Purpose  : MEM stage with D-cache request/stall handshake and MEM/WB register.
//  Options  : ENDIAN_SWAP_EN byte-reverses store data and load data.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_wb_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 30
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] mem_addr_D,
    input  logic [DATA_W-1:0] mem_wdata_D,
    input  logic [4:0]        rd_ex,
    input  logic              memread_ex,
    input  logic              memwrite_ex,
    input  logic              RegWrite_ex,
    input  logic              MemToReg_ex,
    input  logic              stall_ext,
    input  logic              DCACHE_stall,
    input  logic [DATA_W-1:0] DCACHE_rdata,
    output logic              DCACHE_ren,
    output logic              DCACHE_wen,
    output logic [ADDR_W-1:0] DCACHE_addr,
    output logic [DATA_W-1:0] DCACHE_wdata,
    output logic              stall_mem,
    output logic              RegWrite_mem,
    output logic [4:0]        rd_mem,
    output logic [DATA_W-1:0] wdata_wb
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HELD = 2'd2
    } state_t;

    state_t            state_q,    state_d;
    logic [DATA_W-1:0] hold_q,     hold_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        rd_q,       rd_d;
    logic              memtoreg_q, memtoreg_d;
    logic [DATA_W-1:0] alu_q,      alu_d;
    logic [DATA_W-1:0] rdata_q,    rdata_d;

    logic              mem_op;
    logic              req;
    logic              adv;
    logic [DATA_W-1:0] rdata_in;
    logic [DATA_W-1:0] wdata_out;
    logic [DATA_W-1:0] load_data;

`ifdef ENDIAN_SWAP_EN
    function automatic logic [DATA_W-1:0] byte_rev(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W / 8; i++) begin
            r[8*i +: 8] = x[DATA_W-8-8*i +: 8];
        end
        return r;
    endfunction
`endif

    always_comb begin
`ifdef ENDIAN_SWAP_EN
        rdata_in  = byte_rev(DCACHE_rdata);
        wdata_out = byte_rev(mem_wdata_D);
`else
        rdata_in  = DCACHE_rdata;
        wdata_out = mem_wdata_D;
`endif
    end

    // Reset gates the request so nothing reaches the cache while rst_n is low.
    always_comb begin
        mem_op    = memread_ex | memwrite_ex;
        req       = mem_op & (state_q != HELD) & rst_n;
        stall_mem = req & DCACHE_stall;
        adv       = ~stall_mem & ~stall_ext;
        load_data = (state_q == HELD) ? hold_q : rdata_in;
    end

    // A read takes priority so the two strobes can never be high together.
    always_comb begin
        DCACHE_ren   = req & memread_ex;
        DCACHE_wen   = req & memwrite_ex & ~memread_ex;
        DCACHE_addr  = mem_addr_D[ADDR_W+1:2];
        DCACHE_wdata = wdata_out;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (DCACHE_stall) begin
                        state_d = BUSY;
                    end else if (stall_ext) begin
                        state_d = HELD;
                        hold_d  = rdata_in;
                    end
                end
            end
            BUSY: begin
                if (!DCACHE_stall) begin
                    if (stall_ext) begin
                        state_d = HELD;
                        hold_d  = rdata_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HELD: begin
                if (!stall_ext) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        regwrite_d = regwrite_q;
        rd_d       = rd_q;
        memtoreg_d = memtoreg_q;
        alu_d      = alu_q;
        rdata_d    = rdata_q;
        if (adv) begin
            regwrite_d = RegWrite_ex & ~memwrite_ex;
            rd_d       = rd_ex;
            memtoreg_d = MemToReg_ex & ~memwrite_ex;
            alu_d      = mem_addr_D;
            rdata_d    = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            memtoreg_q <= 1'b0;
            alu_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            memtoreg_q <= memtoreg_d;
            alu_q      <= alu_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        RegWrite_mem = regwrite_q;
        rd_mem       = rd_q;
        wdata_wb     = memtoreg_q ? rdata_q : alu_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
//  Module   : tb_mem_wb_stage
//  Purpose  : Scoreboard bench for mem_wb_stage; honours ENDIAN_SWAP_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] mem_addr_D;
    logic [31:0] mem_wdata_D;
    logic [4:0]  rd_ex;
    logic        memread_ex;
    logic        memwrite_ex;
    logic        RegWrite_ex;
    logic        MemToReg_ex;
    logic        stall_ext;
    logic        DCACHE_stall;
    logic [31:0] DCACHE_rdata;
    logic        DCACHE_ren;
    logic        DCACHE_wen;
    logic [29:0] DCACHE_addr;
    logic [31:0] DCACHE_wdata;
    logic        stall_mem;
    logic        RegWrite_mem;
    logic [4:0]  rd_mem;
    logic [31:0] wdata_wb;

    int          total = 0;
    int          bad   = 0;
    logic        tb_valid = 1'b0;
    logic [37:0] sb_q[$];

    always #5 clk = ~clk;

    mem_wb_stage #(.DATA_W(32), .ADDR_W(30)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr_D   (mem_addr_D),
        .mem_wdata_D  (mem_wdata_D),
        .rd_ex        (rd_ex),
        .memread_ex   (memread_ex),
        .memwrite_ex  (memwrite_ex),
        .RegWrite_ex  (RegWrite_ex),
        .MemToReg_ex  (MemToReg_ex),
        .stall_ext    (stall_ext),
        .DCACHE_stall (DCACHE_stall),
        .DCACHE_rdata (DCACHE_rdata),
        .DCACHE_ren   (DCACHE_ren),
        .DCACHE_wen   (DCACHE_wen),
        .DCACHE_addr  (DCACHE_addr),
        .DCACHE_wdata (DCACHE_wdata),
        .stall_mem    (stall_mem),
        .RegWrite_mem (RegWrite_mem),
        .rd_mem       (rd_mem),
        .wdata_wb     (wdata_wb)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] swp(input logic [31:0] x);
`ifdef ENDIAN_SWAP_EN
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
        return x;
`endif
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble;
        rd_ex        = 5'd0;
        RegWrite_ex  = 1'b0;
        MemToReg_ex  = 1'b0;
        memread_ex   = 1'b0;
        memwrite_ex  = 1'b0;
        mem_addr_D   = 32'd0;
        mem_wdata_D  = 32'd0;
        DCACHE_stall = 1'b0;
        stall_ext    = 1'b0;
        tb_valid     = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rd, input logic rw, input logic m2r,
                         input logic rd_en, input logic wr_en, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] cache_rd);
        logic [31:0] exp_data;
        rd_ex        = rd;
        RegWrite_ex  = rw;
        MemToReg_ex  = m2r;
        memread_ex   = rd_en;
        memwrite_ex  = wr_en;
        mem_addr_D   = addr;
        mem_wdata_D  = wd;
        DCACHE_rdata = cache_rd;
        tb_valid     = 1'b1;
        exp_data     = (m2r & ~wr_en) ? swp(cache_rd) : addr;
        sb_q.push_back({rw & ~wr_en, rd, exp_data});
    endtask

    // Called just after a negedge; runs until the advance edge or the budget runs out.
    task automatic retire(input string tag);
        logic adv_now;
        logic done;
        done = 1'b0;
        for (int n = 0; n < 16; n++) begin
            adv_now = !stall_mem && !stall_ext;
            tick();
            if (adv_now) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        logic        fire;
        logic [37:0] e;
        forever begin
            @(negedge clk);
            fire = tb_valid && rst_n && !stall_mem && !stall_ext;
            @(posedge clk);
            #1;
            if (fire) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("wb_regwrite", RegWrite_mem, e[37]);
                    chk("wb_rd",       rd_mem,       e[36:32]);
                    chk("wb_data",     wdata_wb,     e[31:0]);
                end
            end
        end
    end

    initial begin
        bubble();
        DCACHE_rdata = 32'd0;
        rst_n        = 1'b0;
        memread_ex   = 1'b1;
        mem_addr_D   = 32'h100;
        DCACHE_stall = 1'b1;
        #2;
        chk("rst_ren_pre",   DCACHE_ren, 1'b0);
        chk("rst_stall_pre", stall_mem,  1'b0);
        @(negedge clk);
        chk("rst_ren",      DCACHE_ren,   1'b0);
        chk("rst_stall",    stall_mem,    1'b0);
        chk("rst_regwrite", RegWrite_mem, 1'b0);
        chk("rst_rd",       rd_mem,       5'd0);
        chk("rst_wdata",    wdata_wb,     32'd0);
        tick();
        rst_n = 1'b1;
        bubble();

        // ALU op
        drive(5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd0, 32'd0);
        @(negedge clk);
        chk("alu_ren", DCACHE_ren, 1'b0);
        chk("alu_wen", DCACHE_wen, 1'b0);
        retire("alu");

        // load hit
        drive(5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'd0, 32'hCAFEBABE);
        @(negedge clk);
        chk("hit_addr",  DCACHE_addr, 30'h40);
        chk("hit_stall", stall_mem,   1'b0);
        chk("hit_ren",   DCACHE_ren,  1'b1);
        chk("hit_wen",   DCACHE_wen,  1'b0);
        retire("hit");

        // back-to-back misaligned load, one miss cycle
        drive(5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 32'h103, 32'd0, 32'h0BADF00D);
        DCACHE_stall = 1'b1;
        @(negedge clk);
        chk("b2b_ren",   DCACHE_ren,  1'b1);
        chk("mis_addr",  DCACHE_addr, 30'h40);
        chk("b2b_stall", stall_mem,   1'b1);
        tick();
        DCACHE_stall = 1'b0;
        @(negedge clk);
        chk("busy_ren",   DCACHE_ren, 1'b1);
        chk("busy_stall", stall_mem,  1'b0);
        retire("miss1");

        // store miss, 3 stall cycles
        drive(5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 32'h11223344, 32'd0);
        DCACHE_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("st_stall",    stall_mem,    1'b1);
            chk("st_wen",      DCACHE_wen,   1'b1);
            chk("st_ren",      DCACHE_ren,   1'b0);
            chk("st_addr",     DCACHE_addr,  30'h80);
            chk("st_wdata",    DCACHE_wdata, swp(32'h11223344));
            chk("st_regwrite", RegWrite_mem, 1'b1);
            chk("st_rd_hold",  rd_mem,       5'd8);
            tick();
        end
        DCACHE_stall = 1'b0;
        @(negedge clk);
        chk("st_done_stall", stall_mem, 1'b0);
        retire("store");

        // hit while stall_ext is high for 2 cycles
        drive(5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 32'h44, 32'd0, 32'h000000A5);
        stall_ext = 1'b1;
        @(negedge clk);
        chk("held_hit_ren",   DCACHE_ren, 1'b1);
        chk("held_hit_stall", stall_mem,  1'b0);
        tick();
        DCACHE_rdata = 32'hDEAD0000;
        DCACHE_stall = 1'b1;
        @(negedge clk);
        chk("held_ren",   DCACHE_ren, 1'b0);
        chk("held_stall", stall_mem,  1'b0);
        chk("held_rd",    rd_mem,     5'd3);
        tick();
        stall_ext = 1'b0;
        @(negedge clk);
        chk("held_ren2", DCACHE_ren, 1'b0);
        retire("held");
        DCACHE_stall = 1'b0;

        // non-memory op held only by stall_ext
        drive(5'd12, 1'b1, 1'b0, 1'b0, 1'b0, 32'hABCD, 32'd0, 32'd0);
        stall_ext    = 1'b1;
        DCACHE_stall = 1'b1;
        @(negedge clk);
        chk("nm_stall", stall_mem,  1'b0);
        chk("nm_ren",   DCACHE_ren, 1'b0);
        chk("nm_rd",    rd_mem,     5'd9);
        tick();
        stall_ext = 1'b0;
        @(negedge clk);
        retire("nonmem");
        DCACHE_stall = 1'b0;

        // reset in the middle of a miss
        drive(5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'd0, 32'h55);
        DCACHE_stall = 1'b1;
        @(negedge clk);
        chk("rm_stall0", stall_mem, 1'b1);
        tick();
        @(negedge clk);
        chk("rm_stall1", stall_mem, 1'b1);
        rst_n    = 1'b0;
        tb_valid = 1'b0;
        sb_q.delete();
        tick();
        rst_n = 1'b1;
        bubble();
        @(negedge clk);
        chk("rm_ren",      DCACHE_ren,   1'b0);
        chk("rm_stall",    stall_mem,    1'b0);
        chk("rm_regwrite", RegWrite_mem, 1'b0);
        chk("rm_rd",       rd_mem,       5'd0);
        chk("rm_wdata",    wdata_wb,     32'd0);
        tick();

        // ALU op after reset
        drive(5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h77, 32'd0, 32'd0);
        @(negedge clk);
        retire("post_rst");

        bubble();
        @(negedge clk);
        chk("sb_left", sb_q.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
